// File: rtl/stream_addr_arb_mux.sv
// Round-robin many-to-one merge of address streams into one registered output
// stage, tagging each beat with the index of the input it came from.
module stream_addr_arb_mux #(
  parameter int NrInput      = 2,
  parameter int AddressWidth = 32,
  parameter int IdxWidth     = (NrInput > 1) ? $clog2(NrInput) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NrInput-1:0]                     inp_valid_i,
  output logic [NrInput-1:0]                     inp_ready_o,
  input  logic [NrInput-1:0][AddressWidth-1:0]   inp_addr_i,
  output logic                                   oup_valid_o,
  input  logic                                   oup_ready_i,
  output logic [AddressWidth-1:0]                oup_addr_o,
  output logic [IdxWidth-1:0]                    oup_idx_o
);

  logic                full;
  logic [IdxWidth-1:0] rr_q;
  logic [IdxWidth-1:0] gnt;
  logic                gnt_vld;
  logic                avail;
  logic                in_hs;
  int                  j;

  assign avail = ~full | oup_ready_i;

  // Scan downward so the candidate closest to rr_q is the last one written.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    j       = 0;
    for (int k = NrInput-1; k >= 0; k--) begin
      j = (int'(rr_q) + k) % NrInput;
      if (inp_valid_i[j]) begin
        gnt_vld = 1'b1;
        gnt     = IdxWidth'(j);
      end
    end
  end

  assign in_hs       = gnt_vld & avail & ~rst_i;
  assign inp_ready_o = in_hs ? (NrInput'(1) << gnt) : '0;
  assign oup_valid_o = full;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full       <= 1'b0;
      oup_addr_o <= '0;
      oup_idx_o  <= '0;
      rr_q       <= '0;
    end else if (in_hs) begin
      full       <= 1'b1;
      oup_addr_o <= inp_addr_i[gnt];
      oup_idx_o  <= gnt;
      rr_q       <= (int'(gnt) == NrInput-1) ? '0 : gnt + 1'b1;
    end else if (oup_ready_i) begin
      full <= 1'b0;
    end
  end

  a_ready_onehot: assert property (@(posedge clk_i) $onehot0(inp_ready_o));
  a_stall_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (oup_valid_o && !oup_ready_i) |=> ($stable(oup_addr_o) && $stable(oup_idx_o)));
  a_idx_range: assert property (@(posedge clk_i)
    oup_valid_o |-> (int'(oup_idx_o) < NrInput));

endmodule
